// File: rtl/evaluate_taper_sum.sv
// Aligns per-feature mg/eg evaluator terms, sums them, tapers by game phase and
// emits a saturated side-to-move-relative score with a fixed 4-cycle latency.
module evaluate_taper_sum #(
  parameter int EVAL_WIDTH  = 24,
  parameter int TERMS       = 4,
  parameter int PHASE_SHIFT = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TERMS-1:0]              terms_valid,
  input  logic [TERMS*EVAL_WIDTH-1:0]   terms_mg,
  input  logic [TERMS*EVAL_WIDTH-1:0]   terms_eg,
  input  logic                          phase_valid,
  input  logic [PHASE_SHIFT:0]          phase,
  input  logic                          white_to_move,
  output logic signed [EVAL_WIDTH-1:0]  eval_t4,
  output logic                          eval_valid_t4,
  output logic                          align_error
);

  localparam int ACC_W  = EVAL_WIDTH + $clog2(TERMS) + 1;
  localparam int PH_W   = PHASE_SHIFT + 2;
  localparam int PROD_W = ACC_W + PH_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [PHASE_SHIFT:0]      PHASE_MAX = {1'b1, {PHASE_SHIFT{1'b0}}};
  localparam logic signed [SUM_W-1:0]   SAT_HI    = {{(SUM_W-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]   SAT_LO    = -SAT_HI;

  logic                        w_accept;
  logic                        w_misalign;
  logic signed [ACC_W-1:0]     w_mg_sum;
  logic signed [ACC_W-1:0]     w_eg_sum;
  logic [PHASE_SHIFT:0]        w_phase_c;
  logic signed [PH_W-1:0]      w_ph_mg;
  logic signed [PH_W-1:0]      w_ph_eg;
  logic signed [SUM_W-1:0]     w_blend;
  logic signed [EVAL_WIDTH-1:0] w_sat;

  logic                        r_valid1, r_valid2, r_valid3;
  logic                        r_wtm1, r_wtm2, r_wtm3;
  logic signed [ACC_W-1:0]     r_mg1, r_eg1;
  logic [PHASE_SHIFT:0]        r_phase1;
  logic signed [PROD_W-1:0]    r_prod_mg, r_prod_eg;
  logic signed [SUM_W-1:0]     r_shift3;

  // Any valid activity that is not a complete aligned board is a misalignment.
  assign w_accept   = (&terms_valid) & phase_valid;
  assign w_misalign = ((|terms_valid) | phase_valid) & ~w_accept;
  assign w_phase_c  = (phase > PHASE_MAX) ? PHASE_MAX : phase;

  always_comb begin
    w_mg_sum = '0;
    w_eg_sum = '0;
    for (int unsigned k = 0; k < TERMS; k++) begin
      w_mg_sum = w_mg_sum + ACC_W'($signed(terms_mg[k*EVAL_WIDTH +: EVAL_WIDTH]));
      w_eg_sum = w_eg_sum + ACC_W'($signed(terms_eg[k*EVAL_WIDTH +: EVAL_WIDTH]));
    end
  end

  assign w_ph_mg = $signed({1'b0, r_phase1});
  assign w_ph_eg = $signed({1'b0, PHASE_MAX - r_phase1});
  assign w_blend = SUM_W'(r_prod_mg) + SUM_W'(r_prod_eg);

  // Symmetric clamp so the negation for black-to-move can never overflow.
  always_comb begin
    w_sat = r_shift3[EVAL_WIDTH-1:0];
    if (r_shift3 > SAT_HI) begin
      w_sat = SAT_HI[EVAL_WIDTH-1:0];
    end else if (r_shift3 < SAT_LO) begin
      w_sat = SAT_LO[EVAL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid1      <= 1'b0;
      r_valid2      <= 1'b0;
      r_valid3      <= 1'b0;
      eval_valid_t4 <= 1'b0;
      align_error   <= 1'b0;
      r_wtm1        <= 1'b0;
      r_wtm2        <= 1'b0;
      r_wtm3        <= 1'b0;
      r_mg1         <= '0;
      r_eg1         <= '0;
      r_phase1      <= '0;
      r_prod_mg     <= '0;
      r_prod_eg     <= '0;
      r_shift3      <= '0;
      eval_t4       <= '0;
    end else begin
      r_valid1      <= w_accept;
      r_valid2      <= r_valid1;
      r_valid3      <= r_valid2;
      eval_valid_t4 <= r_valid3;
      if (w_misalign) begin
        align_error <= 1'b1;
      end
      r_mg1     <= w_mg_sum;
      r_eg1     <= w_eg_sum;
      r_phase1  <= w_phase_c;
      r_wtm1    <= white_to_move;
      r_prod_mg <= PROD_W'(r_mg1) * PROD_W'(w_ph_mg);
      r_prod_eg <= PROD_W'(r_eg1) * PROD_W'(w_ph_eg);
      r_wtm2    <= r_wtm1;
      r_shift3  <= w_blend >>> PHASE_SHIFT;
      r_wtm3    <= r_wtm2;
      if (r_valid3) begin
        eval_t4 <= r_wtm3 ? w_sat : -w_sat;
      end
    end
  end

endmodule

// File: doc/evaluate_taper_sum.md
Name: evaluate_taper_sum

Overview:
- Streaming sink for the per-feature evaluators (rooks, pawns, king safety, ...). Each evaluator delivers a signed midgame/endgame pair with its own valid.
- Checks that all contributors are aligned, then sums the mg terms and the eg terms separately.
- Blends the two sums by game phase and emits one side-to-move-relative score to the search/negamax stage.
- Fully pipelined: accepts one board per cycle.

Parameters:
- EVAL_WIDTH, 24, signed width of every input term and of the output score.
- TERMS, 4, number of mg/eg contributor pairs; legal range 1..16.
- PHASE_SHIFT, 7, phase full scale is PHASE_MAX = 1 << PHASE_SHIFT, so 128 by default.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- terms_valid  in  TERMS  per-contributor valid; bit k qualifies term k.
- terms_mg  in  TERMS*EVAL_WIDTH  signed mg terms, term k at [k*EVAL_WIDTH +: EVAL_WIDTH].
- terms_eg  in  TERMS*EVAL_WIDTH  signed eg terms, same packing as terms_mg.
- phase_valid  in  1  qualifies phase and white_to_move.
- phase  in  PHASE_SHIFT+1  game phase; PHASE_MAX = pure midgame, 0 = pure endgame.
- white_to_move  in  1  side to move for the same board.
- eval_t4  out  EVAL_WIDTH  signed tapered score, relative to side to move.
- eval_valid_t4  out  1  eval_t4 valid strobe.
- align_error  out  1  sticky flag: contributor misalignment was detected.

Behaviour:
- Reset (synchronous, active-high): eval_t4 = 0, eval_valid_t4 = 0, align_error = 0, all internal valid stages = 0.
  - Reset asserted mid-stream discards every in-flight board; no eval_valid_t4 pulse in the cycle after reset.
- Accept condition, cycle t0: terms_valid all ones AND phase_valid = 1. Only then does a board enter the pipe.
- Misalignment at t0: any of the following sets align_error = 1 at t1 and sends no board down the pipe:
  - terms_valid nonzero but not all ones;
  - terms_valid all ones with phase_valid = 0;
  - phase_valid = 1 with terms_valid = 0.
  - align_error holds until reset.
  - All inputs idle (all valids 0) is legal and raises no error.
- Phase clamp: phase > PHASE_MAX is clamped to PHASE_MAX at t0 capture. No error is raised.
- t1: register the mg sum and the eg sum over all TERMS.
  - Accumulator width is EVAL_WIDTH + clog2(TERMS) + 1, sign-extended, so no overflow is possible.
  - Also register the clamped phase and white_to_move.
- t2: register the products mg_sum*phase and eg_sum*(PHASE_MAX-phase). Signed operands; phase is zero-extended.
- t3: register (prod_mg + prod_eg) >>> PHASE_SHIFT.
  - Arithmetic shift, so rounding is floor (toward -inf); -1 >>> 7 = -1.
- t4: saturate the t3 value to [-(2^(EVAL_WIDTH-1)-1), +(2^(EVAL_WIDTH-1)-1)]. The symmetric range keeps negation safe.
  - eval_t4 = saturated value if white_to_move, else its negation.
  - eval_valid_t4 = 1.
- Latency is exactly 4 cycles from an accepted t0 to eval_valid_t4.
  - Back-to-back boards produce back-to-back outputs in order.
  - No backpressure; the downstream stage must always accept.
- eval_t4 holds its last value when eval_valid_t4 = 0. Its value is don't-care to consumers in that case.
- Valid pipeline runs independently of the datapath, using the same registers-per-stage structure.

Test Plan:
- Single board, TERMS=4, EVAL_WIDTH=24, PHASE_SHIFT=7:
  - Stimulus: mg = {35, 10, -20, 0}, eg = {20, 10, -5, 0}, phase = 128, white_to_move = 1.
  - Required: eval_t4 = 25 exactly 4 cycles later, with one eval_valid_t4 pulse.
- Same terms at phase = 0 with white_to_move = 0 -> eval_t4 = -25. Same terms at phase = 64 -> (25*64 + 25*64) >>> 7 = 25.
- Floor rounding: mg sum = -1, eg sum = 0, phase = 64.
  - (-64) >>> 7 = -1, so eval_t4 = -1.
  - Also apply phase = 200 with mg = 100, eg = 0: clamped to 128, eval_t4 = 100.
- Saturation: all four mg = +8388607, phase = 128 -> eval_t4 = +8388607. Same terms with white_to_move = 0 -> eval_t4 = -8388607.
- Misalignment:
  - Stimulus: terms_valid = 4'b1011 with phase_valid = 1.
  - Required: align_error rises at t1 and stays high; no eval_valid_t4 pulse for that cycle.
  - A following aligned board still produces a correct result 4 cycles after its t0.
- Streaming plus reset:
  - Stimulus: 10 consecutive aligned boards with distinct terms; assert reset for 1 cycle during the 6th board's t0.
  - Required: boards 1-2 emerge in order; boards 3-6 are discarded (no pulses in the 4 cycles after reset); boards 7-10 emerge with correct values; align_error = 0.
